serial_tx_ctrl: RTL and testbench

SERIAL_TX_CTRL -- requirements
Module: serial_tx_ctrl

---
 rtl/elc3_serial_pkg.sv | 20 ++
 rtl/serial_tx_ctrl_if.sv | 25 ++
 rtl/RShiftRegister.sv | 40 ++++
 rtl/serial_tx_ctrl.sv | 129 ++++++++++++
 tb/tb_serial_tx_ctrl.sv | 155 +++++++++++++++
 5 files changed

// File: rtl/elc3_serial_pkg.sv
// Shared types and defaults for the serial transmit controller.
// Holds the FSM state encoding and the counter width helper.
package elc3_serial_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_t;

    localparam int DEF_DATA_W       = 8;
    localparam int DEF_CLKS_PER_BIT = 434;

    // Width needed to count 0 .. n-1, never less than one bit.
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/serial_tx_ctrl_if.sv
// Word handshake between a requester and the serial transmitter.
// The requester is the master; the transmitter is the slave.
interface serial_tx_ctrl_if
    import elc3_serial_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W
);

    logic [DATA_W-1:0] TxData;
    logic              TxValid;
    logic              TxReady;

    modport master (
        output TxData,
        output TxValid,
        input  TxReady
    );

    modport slave (
        input  TxData,
        input  TxValid,
        output TxReady
    );

endinterface

// File: rtl/RShiftRegister.sv
// Right shift register with parallel load; bit 0 is the serial output.
// NextOut exposes what bit 0 will hold after a shift, so the caller can register it.
module RShiftRegister #(
    parameter int N = 8
) (
    input  logic         Clk,
    input  logic         Reset,
    input  logic         Load,
    input  logic         ShiftEnable,
    input  logic         ShiftIn,
    input  logic [N-1:0] DataIn,
    output logic         ShiftOut,
    output logic         NextOut
);

    logic [N-1:0] q;
    logic [N-1:0] shifted;

    generate
        if (N > 1) begin : g_wide
            assign shifted = {ShiftIn, q[N-1:1]};
        end else begin : g_one
            assign shifted = ShiftIn;
        end
    endgenerate

    always_ff @(posedge Clk) begin
        if (Reset) begin
            q <= '0;
        end else if (Load) begin
            q <= DataIn;
        end else if (ShiftEnable) begin
            q <= shifted;
        end
    end

    assign ShiftOut = q[0];
    assign NextOut  = shifted[0];

endmodule

// File: rtl/serial_tx_ctrl.sv
// Serial transmitter: start bit, DATA_W data bits LSB first, stop bit,
// each held for CLKS_PER_BIT clocks. Accepts one word per frame via a valid/ready handshake.
//
//   state | meaning
//   IDLE  | line high, TxReady asserted, waiting for a word
//   START | start bit (Tx = 0) for one bit period
//   DATA  | shifting out data bits, bit counter tracks position
//   STOP  | stop bit (Tx = 1) for one bit period, then back to IDLE
module serial_tx_ctrl
    import elc3_serial_pkg::*;
#(
    parameter int DATA_W       = DEF_DATA_W,
    parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT
) (
    input  logic             Clk,
    input  logic             Reset,
    serial_tx_ctrl_if.slave  bus,
    output logic             Tx,
    output logic             Busy
);

    localparam int BAUD_W = cnt_w(CLKS_PER_BIT);
    localparam int BIT_W  = cnt_w(DATA_W);

    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_W - 1);

    tx_state_t         state;
    logic [BAUD_W-1:0] baud_cnt;
    logic [BIT_W-1:0]  bit_cnt;
    logic              tx_q;
    logic              busy_q;

    logic load;
    logic shift_en;
    logic baud_end;
    logic bit_end;
    logic shift_out;
    logic next_out;
    logic data_bit;

    assign bus.TxReady = (state == IDLE) && Reset;
    assign load        = bus.TxValid && bus.TxReady;
    assign baud_end    = (baud_cnt == BAUD_LAST);
    assign bit_end     = (bit_cnt == BIT_LAST);
    assign shift_en    = (state == DATA) && baud_end;

    // Bit 0 as it will stand after this edge, so Tx stays a clean register.
    assign data_bit = shift_en ? next_out : shift_out;

    RShiftRegister #(
        .N (DATA_W)
    ) u_sreg (
        .Clk         (Clk),
        .Reset       (!Reset),
        .Load        (load),
        .ShiftEnable (shift_en),
        .ShiftIn     (1'b1),
        .DataIn      (bus.TxData),
        .ShiftOut    (shift_out),
        .NextOut     (next_out)
    );

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            state    <= IDLE;
            baud_cnt <= '0;
            bit_cnt  <= '0;
            tx_q     <= 1'b1;
            busy_q   <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (load) begin
                        state    <= START;
                        baud_cnt <= '0;
                        bit_cnt  <= '0;
                        tx_q     <= 1'b0;
                        busy_q   <= 1'b1;
                    end
                end
                START: begin
                    if (baud_end) begin
                        state    <= DATA;
                        baud_cnt <= '0;
                        tx_q     <= data_bit;
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (baud_end) begin
                        baud_cnt <= '0;
                        if (bit_end) begin
                            state   <= STOP;
                            bit_cnt <= '0;
                            tx_q    <= 1'b1;
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                            tx_q    <= data_bit;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                STOP: begin
                    if (baud_end) begin
                        state    <= IDLE;
                        baud_cnt <= '0;
                        busy_q   <= 1'b0;
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                default: begin
                    state    <= IDLE;
                    baud_cnt <= '0;
                    bit_cnt  <= '0;
                    tx_q     <= 1'b1;
                    busy_q   <= 1'b0;
                end
            endcase
        end
    end

    assign Tx   = tx_q;
    assign Busy = busy_q;

endmodule

// File: tb/tb_serial_tx_ctrl.sv
// Bench for serial_tx_ctrl with DATA_W = 8, CLKS_PER_BIT = 4: directed frames
// followed by randomized frames, checked against an expected-waveform model.
module tb_serial_tx_ctrl;

    localparam int DW    = 8;
    localparam int CPB   = 4;
    localparam int FRAME = (DW + 2) * CPB;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    logic tx;
    logic busy;

    int checks    = 0;
    int errors    = 0;
    int shift_cnt = 0;
    int overlap   = 0;

    serial_tx_ctrl_if #(.DATA_W(DW)) bus ();

    serial_tx_ctrl #(
        .DATA_W       (DW),
        .CLKS_PER_BIT (CPB)
    ) dut (
        .Clk   (clk),
        .Reset (reset),
        .bus   (bus),
        .Tx    (tx),
        .Busy  (busy)
    );

    always #5 clk = ~clk;

    // Strobes are sampled at the edge that acts on them.
    always @(posedge clk) begin
        if (dut.load) shift_cnt <= 0;
        else if (dut.shift_en) shift_cnt <= shift_cnt + 1;
        if (dut.load && dut.shift_en) overlap <= overlap + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Line level i cycles after the frame starts: start, data LSB first, stop.
    function automatic logic exp_bit(input logic [7:0] d, input int i);
        int b;
        b = i / CPB;
        if (b == 0) return 1'b0;
        if (b > DW) return 1'b1;
        return d[b-1];
    endfunction

    // Called at a negedge with the DUT idle; returns at a negedge with the DUT idle.
    task automatic run_frame(input logic [7:0] d, input bit noise, input bit hold, input int abort_at);
        chk("ready_idle", 32'(bus.TxReady), 32'd1);
        chk("tx_idle", 32'(tx), 32'd1);
        bus.TxData  = d;
        bus.TxValid = 1'b1;
        @(negedge clk);
        if (!hold) bus.TxValid = 1'b0;
        for (int i = 0; i < FRAME; i++) begin
            chk("tx_bit", 32'(tx), 32'(exp_bit(d, i)));
            chk("busy_frame", 32'(busy), 32'd1);
            chk("ready_frame", 32'(bus.TxReady), 32'd0);
            if (i == abort_at) begin
                reset       = 1'b0;
                bus.TxValid = 1'b1;
                @(negedge clk);
                chk("abort_tx", 32'(tx), 32'd1);
                chk("abort_busy", 32'(busy), 32'd0);
                chk("abort_ready", 32'(bus.TxReady), 32'd0);
                chk("abort_sreg", 32'(dut.u_sreg.q), 32'd0);
                @(negedge clk);
                chk("abort_hold_tx", 32'(tx), 32'd1);
                chk("abort_hold_busy", 32'(busy), 32'd0);
                reset       = 1'b1;
                bus.TxValid = 1'b0;
                #1;
                chk("ready_release", 32'(bus.TxReady), 32'd1);
                return;
            end
            if (noise) begin
                bus.TxData = 8'($urandom);
                if (!hold) bus.TxValid = 1'($urandom);
            end
            @(negedge clk);
        end
        if (!hold) bus.TxValid = 1'b0;
        chk("busy_end", 32'(busy), 32'd0);
        chk("ready_end", 32'(bus.TxReady), 32'd1);
        chk("tx_end", 32'(tx), 32'd1);
        chk("shift_pulses", 32'(shift_cnt), 32'(DW));
        chk("load_shift_overlap", 32'(overlap), 32'd0);
    endtask

    logic [7:0] rd;
    bit         rnoise;
    bit         rhold;
    int         rabort;

    initial begin
        bus.TxValid = 1'b0;
        bus.TxData  = '0;
        reset       = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("rst_tx", 32'(tx), 32'd1);
            chk("rst_busy", 32'(busy), 32'd0);
            chk("rst_ready", 32'(bus.TxReady), 32'd0);
        end
        reset = 1'b1;
        #1;
        chk("ready_after_rst", 32'(bus.TxReady), 32'd1);

        run_frame(8'hA5, 1'b0, 1'b0, -1);
        run_frame(8'h00, 1'b0, 1'b1, -1);
        run_frame(8'hFF, 1'b0, 1'b0, -1);
        run_frame(8'h3C, 1'b0, 1'b0, 4 * CPB + 1);
        run_frame(8'h81, 1'b0, 1'b0, -1);
        run_frame(8'h5A, 1'b1, 1'b0, -1);

        reset       = 1'b0;
        bus.TxValid = 1'b1;
        bus.TxData  = 8'hC3;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("rst_low_ready", 32'(bus.TxReady), 32'd0);
            chk("rst_low_tx", 32'(tx), 32'd1);
            chk("rst_low_busy", 32'(busy), 32'd0);
        end
        reset = 1'b1;
        #1;
        run_frame(8'hC3, 1'b0, 1'b0, -1);

        for (int n = 0; n < 24; n++) begin
            rd     = 8'($urandom);
            rnoise = 1'($urandom);
            rhold  = ($urandom_range(0, 3) == 0);
            rabort = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, FRAME - 1)) : -1;
            run_frame(rd, rnoise, rhold, rabort);
        end
        bus.TxValid = 1'b0;
        repeat (2) @(negedge clk);
        chk("final_idle_busy", 32'(busy), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
